pattern_fsm: RTL and testbench

Parametrised serial sequence detector: a binary-encoded state machine that watches a one-bit stream `w` for a run-time-programmable pattern of `LEN` bits. It supports overlapping and non-overlapping detection and keeps a saturating match count. It is the general successor to the fixed five-state detector and sits directly on the serial input path, with `z` feeding downstream control.

---
 rtl/pattern_fsm_if.sv | 28 ++
 rtl/pattern_fsm.sv | 109 ++++++++++
 tb/tb_pattern_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pattern_fsm_if.sv
// Port bundle for pattern_fsm: stream, pattern-load and counter controls in,
// registered match pulse, state and match count out.
interface pattern_fsm_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
);
    localparam int SW = (LEN < 3) ? 1 : $clog2(LEN);

    logic             en;
    logic             w;
    logic             load;
    logic [LEN-1:0]   pattern;
    logic             overlap;
    logic             cnt_clr;
    logic             z;
    logic [SW-1:0]    state;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, w, load, pattern, overlap, cnt_clr,
        input  z, state, match_cnt
    );

    modport slave (
        input  en, w, load, pattern, overlap, cnt_clr,
        output z, state, match_cnt
    );
endinterface

// File: rtl/pattern_fsm.sv
// Run-time programmable serial sequence detector with KMP fallback,
// overlapping/non-overlapping modes and a saturating match counter.
module pattern_fsm #(
    parameter int             LEN         = 4,
    parameter int             CNT_W       = 8,
    parameter logic [LEN-1:0] RST_PATTERN = LEN'(4'b1011),
    parameter bit             RST_OVERLAP = 1'b1,
    localparam int            SW          = (LEN < 3) ? 1 : $clog2(LEN)
) (
    input  logic        clk,
    input  logic        reset,
    pattern_fsm_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SW-1:0]    state_q, state_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic             ovl_q, ovl_d;

    int   kmp_j;
    int   border;
    logic match;

    // Longest j <= k+1 such that the tail of P(k)·w equals P(j); j == LEN is a match.
    always_comb begin : kmp_next
        int   k;
        int   p;
        logic ok;
        logic sb;
        kmp_j = 0;
        k     = int'(state_q);
        for (int j = 1; j <= LEN; j++) begin
            ok = (j <= k + 1);
            for (int i = 0; i < LEN; i++) begin
                p  = 0;
                sb = 1'b0;
                if (ok && i < j) begin
                    p  = k + 1 - j + i;
                    sb = (p == k) ? bus.w : pat_q[LEN-1-p];
                    if (sb != pat_q[LEN-1-i]) ok = 1'b0;
                end
            end
            if (ok) kmp_j = j;
        end
    end

    // Longest proper border of the full pattern: resume point after an overlapping match.
    always_comb begin : pat_border
        logic ok;
        border = 0;
        for (int j = 1; j < LEN; j++) begin
            ok = 1'b1;
            for (int i = 0; i < LEN; i++) begin
                if (i < j && pat_q[j-1-i] != pat_q[LEN-1-i]) ok = 1'b0;
            end
            if (ok) border = j;
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no latch can form.
    always_comb begin : next_state
        state_d = state_q;
        z_d     = 1'b0;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        match   = 1'b0;
        if (bus.load) begin
            pat_d   = bus.pattern;
            ovl_d   = bus.overlap;
            state_d = '0;
        end else if (bus.en) begin
            if (kmp_j == LEN) begin
                match   = 1'b1;
                state_d = ovl_q ? SW'(border) : '0;
            end else begin
                state_d = SW'(kmp_j);
            end
        end
        z_d = match;

        // Clear first, then count, so a clear on a match edge reads 1.
        cnt_d = bus.cnt_clr ? '0 : cnt_q;
        if (match && cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            pat_q   <= RST_PATTERN;
            ovl_q   <= RST_OVERLAP;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_pattern_fsm.sv
// Directed bench for pattern_fsm: one default instance (CNT_W=8) and one with
// CNT_W=2, both fed the same stimulus; expectations are hand-computed.
module tb_pattern_fsm;
    logic       clk;
    logic       reset;
    logic       en, w, load, overlap, cnt_clr;
    logic [3:0] pattern;

    int total = 0;
    int bad   = 0;

    pattern_fsm_if #(.LEN(4), .CNT_W(8)) ia ();
    pattern_fsm_if #(.LEN(4), .CNT_W(2)) ib ();

    assign ia.en = en;      assign ib.en = en;
    assign ia.w = w;        assign ib.w = w;
    assign ia.load = load;  assign ib.load = load;
    assign ia.pattern = pattern; assign ib.pattern = pattern;
    assign ia.overlap = overlap; assign ib.overlap = overlap;
    assign ia.cnt_clr = cnt_clr; assign ib.cnt_clr = cnt_clr;

    pattern_fsm #(.LEN(4), .CNT_W(8)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
    pattern_fsm #(.LEN(4), .CNT_W(2)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic e, input logic b, input logic clr);
        @(negedge clk);
        en = e; w = b; load = 1'b0; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // en and w are set high on the load edge to show they are ignored.
    task automatic do_load(input logic [3:0] p, input logic o);
        @(negedge clk);
        load = 1'b1; pattern = p; overlap = o; en = 1'b1; w = 1'b1; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // '1'/'0' accept a bit, '.' is an en=0 cycle; expected state/z per cycle as digits.
    task automatic run_seq(input string tag, input string bits, input string states, input string zs);
        for (int i = 0; i < bits.len(); i++) begin
            if (bits[i] == ".") cycle(1'b0, 1'b0, 1'b0);
            else                cycle(1'b1, bits[i] == "1", 1'b0);
            check($sformatf("%s.state[%0d]", tag, i), 32'(ia.state), 32'(states[i] - "0"));
            check($sformatf("%s.z[%0d]", tag, i), 32'(ia.z), 32'(zs[i] - "0"));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; w = 1'b0; load = 1'b0; cnt_clr = 1'b0;
        overlap = 1'b1; pattern = 4'b1011;
        #3;
        check("rst.state", 32'(ia.state), 0);
        check("rst.z", 32'(ia.z), 0);
        check("rst.cnt_a", 32'(ia.match_cnt), 0);
        check("rst.cnt_b", 32'(ib.match_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Overlap mode with the reset pattern 1011.
        run_seq("ovl", "1011011", "1231231", "0001001");
        check("ovl.cnt", 32'(ia.match_cnt), 2);

        // Non-overlap mode; load leaves the counter alone and clears state.
        do_load(4'b1011, 1'b0);
        check("ld1.state", 32'(ia.state), 0);
        check("ld1.z", 32'(ia.z), 0);
        check("ld1.cnt", 32'(ia.match_cnt), 2);
        run_seq("novl", "1011011", "1230011", "0001000");
        check("novl.cnt", 32'(ia.match_cnt), 3);

        // KMP fallback in overlap mode.
        do_load(4'b1011, 1'b1);
        run_seq("fb", "10101011", "12323231", "00000001");
        check("fb.cnt", 32'(ia.match_cnt), 4);

        // en gaps: state holds, z only after the last accepted bit.
        run_seq("gap", "1.0..1.1.", "112223311", "000000010");
        check("gap.cnt", 32'(ia.match_cnt), 5);

        // Asynchronous reset mid-cycle with a partial match in flight.
        run_seq("pre", "101", "123", "000");
        #3;
        reset = 1'b0;
        #1;
        check("amid.state", 32'(ia.state), 0);
        check("amid.z", 32'(ia.z), 0);
        check("amid.cnt_a", 32'(ia.match_cnt), 0);
        check("amid.cnt_b", 32'(ib.match_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        run_seq("post", "1011", "1231", "0001");
        check("post.cnt", 32'(ia.match_cnt), 1);

        // Saturation of the 2-bit counter after five matches.
        run_seq("sat", "011011011011", "231231231231", "001001001001");
        check("sat.cnt_a", 32'(ia.match_cnt), 5);
        check("sat.cnt_b", 32'(ib.match_cnt), 3);
        run_seq("sat2", "011", "231", "001");
        check("sat2.cnt_a", 32'(ia.match_cnt), 6);
        check("sat2.cnt_b", 32'(ib.match_cnt), 3);

        // Clear on a match edge gives 1; clear without a match gives 0.
        run_seq("clr", "01", "23", "00");
        cycle(1'b1, 1'b1, 1'b1);
        check("clrm.z", 32'(ia.z), 1);
        check("clrm.cnt_a", 32'(ia.match_cnt), 1);
        check("clrm.cnt_b", 32'(ib.match_cnt), 1);
        cycle(1'b1, 1'b0, 1'b1);
        check("clr0.state", 32'(ia.state), 2);
        check("clr0.cnt_a", 32'(ia.match_cnt), 0);
        check("clr0.cnt_b", 32'(ib.match_cnt), 0);

        // New pattern 0110, non-overlap.
        do_load(4'b0110, 1'b0);
        check("ld2.state", 32'(ia.state), 0);
        check("ld2.state_b", 32'(ib.state), 0);
        run_seq("p0110", "0110110", "1230001", "0001000");
        check("p0110.cnt_a", 32'(ia.match_cnt), 1);
        check("p0110.cnt_b", 32'(ib.match_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
